// File: rtl/reset_sequencer.sv
// Purpose : reset sequencer. It synchronises and glitch-filters NUM_SRC async active-low reset
//           requests and merges them with a software request. It asserts all NUM_OUT resets
//           together, releases them in index order, and records the cause of the last reset.
// Latency : an async request reaches rst_n_o within SYNC_STAGES+FILT_CYCLES+1 edges. A software
//           request reaches rst_n_o on the next edge. Output k releases HOLD+k*STEP edges after
//           all requests clear.
// Backpressure: none; requests are level/pulse inputs and are never stalled or dropped.
// Ports:
//   clk, rst      - rising-edge clock; synchronous active-high block reset
//   asyncrst_n_i  - asynchronous active-low reset requests, one per source
//   sw_rst_req    - single-cycle synchronous software reset request
//   cause_clr     - synchronous clear of src_cause (a new set in the same cycle wins)
//   rst_n_o       - sequenced active-low resets; bit 0 is released first
//   all_released  - high while in RUN (every rst_n_o bit high)
//   src_cause     - sticky cause bits: [i] = async source i, [NUM_SRC] = software
module reset_sequencer #(
    parameter int NUM_SRC     = 2,
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] asyncrst_n_i,
    input  logic               sw_rst_req,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               all_released,
    output logic [NUM_SRC:0]   src_cause
);

    localparam int MAX_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int MAX_ALL = (MAX_HS > FILT_CYCLES) ? MAX_HS : FILT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      FILT_MAX  = CW'(FILT_CYCLES);
    localparam logic [CW-1:0]      HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]      STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [NUM_OUT-1:0] OUT_ONE   = NUM_OUT'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Request synchronisers. They reset to 1, which means "no request".
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q [NUM_SRC];
    logic [NUM_SRC-1:0]     req_sync;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst) begin
                sync_q[i] <= '1;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], asyncrst_n_i[i]};
            end
        end
    end

    always_comb begin
        req_sync = '1;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_sync[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter. A source counts as requesting only after FILT_CYCLES
    // consecutive low samples. The request drops on the first high sample.
    // ------------------------------------------------------------------
    logic [CW-1:0]      filt_q [NUM_SRC];
    logic [NUM_SRC-1:0] req_act;
    logic [NUM_SRC-1:0] req_act_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst || req_sync[i]) begin
                filt_q[i] <= '0;
            end else if (filt_q[i] != FILT_MAX) begin
                filt_q[i] <= filt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        req_act = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_act[i] = (filt_q[i] == FILT_MAX);
        end
    end

    logic any_req;
    assign any_req = (|req_act) | sw_rst_req;

    // ------------------------------------------------------------------
    // Cause capture. Only a rising edge of a filtered request sets a bit,
    // so a long-held request does not re-set a bit that was just cleared.
    // ------------------------------------------------------------------
    logic [NUM_SRC:0] cause_set;
    logic [NUM_SRC:0] cause_q;

    assign cause_set = {sw_rst_req, req_act & ~req_act_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            req_act_q <= '0;
            cause_q   <= '0;
        end else begin
            req_act_q <= req_act;
            cause_q   <= cause_clr ? cause_set : (cause_q | cause_set);
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM. A single timer counts the hold period and then each
    // release step. The outputs form a thermometer code that is shifted up
    // by one bit at each expiry.
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CW-1:0]      tmr_q, tmr_d;
    logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
    logic               all_rel_q, all_rel_d;
    logic [NUM_OUT-1:0] rst_n_step;

    assign rst_n_step = (rst_n_q << 1) | OUT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ASSERT;
            tmr_q     <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            rst_n_q   <= rst_n_d;
            all_rel_q <= all_rel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        rst_n_d   = rst_n_q;
        all_rel_d = all_rel_q;

        // Any request restarts the whole sequence. It takes priority over
        // a timer expiry in the same cycle.
        if (any_req) begin
            state_d   = ST_ASSERT;
            rst_n_d   = '0;
            all_rel_d = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rst_n_d = '0;
                    tmr_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
                ST_HOLD, ST_RELEASE: begin
                    if (tmr_q == '0) begin
                        rst_n_d = rst_n_step;
                        tmr_d   = STEP_LOAD;
                        // The top bit is set on this edge, so go straight to RUN.
                        // With NUM_OUT==1 this happens directly from HOLD.
                        if (rst_n_step[NUM_OUT-1]) begin
                            state_d   = ST_RUN;
                            all_rel_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        tmr_d = tmr_q - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    rst_n_d   = '1;
                    all_rel_d = 1'b1;
                end
                default: begin
                    state_d   = ST_ASSERT;
                    rst_n_d   = '0;
                    all_rel_d = 1'b0;
                end
            endcase
        end
    end

    assign rst_n_o      = rst_n_q;
    assign all_released = all_rel_q;
    assign src_cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with default parameters. Each stimulus pushes the output edges it
// should cause, with their cycle windows, into a queue. A monitor pops one entry on every
// rst_n_o change and compares value, all_released and timing.
module tb_reset_sequencer;

    localparam int NO  = 4;
    localparam int H   = 16;
    localparam int S   = 8;
    localparam int LAT = 5;   // sync stages + filter cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] arn = 2'b11;
    logic       sw  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] rn;
    logic       allr;
    logic [2:0] cause;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_SRC(2), .NUM_OUT(NO), .SYNC_STAGES(2),
        .FILT_CYCLES(3), .HOLD_CYCLES(H), .STEP_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .asyncrst_n_i(arn),
        .sw_rst_req(sw),
        .cause_clr(clr),
        .rst_n_o(rn),
        .all_released(allr),
        .src_cause(cause)
    );

    typedef struct {
        logic [3:0]  val;
        logic        allr;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  prev = 4'b0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor; samples 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (rn !== prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_change", {28'd0, rn}, {28'd0, prev});
            end else begin
                mon_e = exp_q.pop_front();
                chk("rst_n_o", {28'd0, rn}, {28'd0, mon_e.val});
                chk("all_released", {31'd0, allr}, {31'd0, mon_e.allr});
                if (mon_e.lo == mon_e.hi)
                    chk("edge_cycle", cyc, mon_e.lo);
                else
                    chk("edge_in_window", {31'd0, (cyc >= mon_e.lo && cyc <= mon_e.hi)}, 32'd1);
            end
            prev = rn;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_assert(input int unsigned lo, input int unsigned hi);
        exp_q.push_back('{val: 4'b0000, allr: 1'b0, lo: lo, hi: hi});
    endtask

    // t = first edge on which ASSERT sees no request
    task automatic push_rel(input int unsigned t);
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < NO; k++) begin
            v[k] = 1'b1;
            exp_q.push_back('{val: v, allr: (k == NO - 1), lo: t + H + k * S, hi: t + H + k * S});
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic wait_val(input logic [3:0] v, input int budget);
        int n;
        n = 0;
        while (rn !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach_value", {28'd0, rn}, {28'd0, v});
    endtask

    // Async request low for len sampling edges, starting at the next edge.
    task automatic async_req(input int idx, input int len);
        int unsigned c;
        c = cyc;
        if (len >= LAT) begin
            push_assert(c + 1, c + 1 + LAT);
            push_rel(c + len + 4);
        end
        arn[idx] = 1'b0;
        tick(len);
        arn[idx] = 1'b1;
    endtask

    task automatic sw_req(input logic with_clr);
        int unsigned c;
        c = cyc;
        push_assert(c + 1, c + 1);
        push_rel(c + 2);
        sw  = 1'b1;
        clr = with_clr;
        tick(1);
        sw  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned c;
        // Reset state
        tick(2);
        chk("reset_rst_n", {28'd0, rn}, 32'h0);
        chk("reset_allr", {31'd0, allr}, 32'h0);
        chk("reset_cause", {29'd0, cause}, 32'h0);
        tick(2);
        c = cyc;
        push_rel(c + 1);
        rst = 1'b0;
        wait_drain(100);
        chk("t1_allr", {31'd0, allr}, 32'h1);
        chk("t1_cause", {29'd0, cause}, 32'h0);

        // Short glitch is filtered out
        tick(3);
        async_req(0, 2);
        tick(10);
        chk("t2_glitch_rst_n", {28'd0, rn}, 32'hf);
        chk("t2_glitch_cause", {29'd0, cause}, 32'h0);
        // A real request, interrupted mid-release by source 1
        async_req(0, 6);
        wait_val(4'b0011, 100);
        chk("t2_cause", {29'd0, cause}, 32'h1);
        exp_q.delete();
        async_req(1, 5);
        wait_drain(150);
        chk("t3_cause", {29'd0, cause}, 32'h3);

        // Software request in RUN
        tick(3);
        sw_req(1'b0);
        wait_drain(100);
        chk("t4_cause", {29'd0, cause}, 32'h7);

        // cause_clr alone
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t6_clr_alone", {29'd0, cause}, 32'h0);

        // Long request: outputs stay low the whole time
        tick(2);
        async_req(1, 100);
        wait_drain(150);
        chk("t5_cause", {29'd0, cause}, 32'h2);

        // Clear coincident with a new software request: the set wins
        tick(2);
        sw_req(1'b1);
        chk("t6_clr_vs_set", {29'd0, cause}, 32'h4);
        wait_val(4'b0001, 40);

        // Block reset mid-release
        exp_q.delete();
        c = cyc;
        push_assert(c + 1, c + 1);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_rst_n", {28'd0, rn}, 32'h0);
        chk("t6_rst_cause", {29'd0, cause}, 32'h0);
        tick(1);
        push_rel(c + 3);
        rst = 1'b0;
        wait_drain(100);
        chk("final_allr", {31'd0, allr}, 32'h1);
        chk("final_rst_n", {28'd0, rn}, 32'hf);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
